shared_mem_arbiter: RTL
=======================

SHARED_MEM_ARBITER -- requirements
Module: shared_mem_arbiter

Interface
REQ-001 SHALL have parameter N_CORES, default 16, number of requesting cores.
REQ-002 SHALL have parameter N_BANKS, default 16, number of memory banks; power of two, at least 2.
REQ-003 SHALL have parameter ADDR_W, default 12, address width per core; low log2(N_BANKS) bits select the bank.
REQ-004 SHALL have parameter DATA_W, default 8, data width per core.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port rd_req  input  N_CORES  per-core load request, level, held until done.
REQ-008 SHALL have port wr_req  input  N_CORES  per-core store request, level, held until done.
REQ-009 SHALL have port addr_in  input  N_CORES*ADDR_W  packed addresses, core i at bits [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port wdata_in  input  N_CORES*DATA_W  packed store data, core i at [i*DATA_W +: DATA_W].
REQ-011 SHALL have port rdata_out  output  N_CORES*DATA_W  packed registered load data per core.
REQ-012 SHALL have port done  output  N_CORES  one-cycle completion pulse per core.
REQ-013 SHALL have port conflict_cnt  output  16  saturating count of conflict cycles.

Function
REQ-014 SHALL hold N_BANKS banks, each 2^(ADDR_W-log2(N_BANKS)) words of DATA_W bits; word index = addr_in bits above the bank field.
REQ-015 SHALL treat core i as eligible in cycle t when (rd_req[i] or wr_req[i]) is high and done[i] is low in t.
REQ-016 SHALL treat a core asserting both rd_req and wr_req as a store; the load is ignored.
REQ-017 SHALL, per bank, grant at most one eligible core per cycle among cores whose bank field selects that bank.
REQ-018 SHALL arbitrate per bank by round-robin: search starts at that bank's pointer, ascending core index, wrapping at N_CORES.
REQ-019 SHALL set a bank's pointer to (g+1) mod N_CORES after granting core g; pointer unchanged when that bank grants nobody.
REQ-020 SHALL, for a granted store in cycle t, write wdata_in of that core into the addressed word at the end of t.
REQ-021 SHALL, for a granted load in cycle t, register the addressed word into that core's rdata_out slice at the end of t.
REQ-022 SHALL assert done[g] for exactly cycle t+1 after a grant to core g in cycle t (1-cycle latency), for loads and stores.
REQ-023 SHALL leave rdata_out slices unchanged except on a granted load to that core.
REQ-024 SHALL, for a load and store to the same word granted in the same cycle (impossible in one bank) -- none; same-bank accesses are serialised, load in a later cycle returns the stored value.
REQ-025 SHALL drop, without side effects, a request deasserted before its grant; a granted request completes regardless of later deassertion.
REQ-026 SHALL increment conflict_cnt by 1 in each cycle in which at least one eligible core is not granted; saturate at 16'hFFFF.
REQ-027 SHALL permit different banks to be served in the same cycle; up to min(N_CORES, N_BANKS) grants per cycle.

Reset
REQ-028 SHALL, while reset is low, force done to 0, rdata_out to 0, conflict_cnt to 0 and all bank pointers to 0, asynchronously.
REQ-029 SHALL discard any grant pending at reset assertion; no done pulse after reset release for pre-reset requests.
REQ-030 SHALL not reset memory contents; contents are undefined until written.

Verification
REQ-031 Reset low mid-traffic -> done=0, rdata_out=0, conflict_cnt=0 immediately, before next clk edge.
REQ-032 Core 3 stores 8'hA5 to 12'h012, then loads 12'h012 -> done[3] one cycle after each grant; rdata_out core 3 = 8'hA5.
REQ-033 Cores 0 and 1 load 12'h002 and 12'h012 (both bank 2) same cycle from reset -> core 0 done at t+1, core 1 done at t+2, conflict_cnt = 1.
REQ-034 Cores 0..15 each access distinct banks (addr = i) same cycle -> all 16 done at t+1, conflict_cnt = 0.
REQ-035 Cores 0 and 5 continuously re-request bank 0 -> grants alternate 0,5,0,5; neither starved.
REQ-036 Core 7 asserts rd_req and wr_req together with wdata 8'h3C at 12'h047 -> store performed, rdata_out core 7 unchanged, later load returns 8'h3C.

Source files
------------

// File: rtl/shared_mem_arbiter.sv
// Banked shared memory: per-bank round-robin arbitration across cores, one grant per bank per cycle.
// Grant in cycle t gives a done pulse (and load data) in t+1; losers hold their level request and retry.
module shared_mem_arbiter #(
  parameter int N_CORES = 16,
  parameter int N_BANKS = 16,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_CORES-1:0]          rd_req,
  input  logic [N_CORES-1:0]          wr_req,
  input  logic [N_CORES*ADDR_W-1:0]   addr_in,
  input  logic [N_CORES*DATA_W-1:0]   wdata_in,
  output logic [N_CORES*DATA_W-1:0]   rdata_out,
  output logic [N_CORES-1:0]          done,
  output logic [15:0]                 conflict_cnt
);

  localparam int BANK_W = $clog2(N_BANKS);
  localparam int WORD_W = ADDR_W - BANK_W;
  localparam int DEPTH  = 1 << WORD_W;
  localparam int PTR_W  = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  logic [BANK_W-1:0] core_bank [N_CORES];
  logic [WORD_W-1:0] core_word [N_CORES];
  logic [DATA_W-1:0] core_wdat [N_CORES];
  logic [N_CORES-1:0] elig;
  logic [N_CORES-1:0] grant;
  logic [PTR_W-1:0]   ptr_q [N_BANKS];
  logic [PTR_W-1:0]   ptr_d [N_BANKS];
  logic [N_BANKS-1:0] bank_we;
  logic [WORD_W-1:0]  bank_widx [N_BANKS];
  logic [DATA_W-1:0]  bank_wdat [N_BANKS];
  logic [DATA_W-1:0]  mem [N_BANKS][DEPTH];
  logic [N_CORES-1:0] done_q;
  logic [DATA_W-1:0]  rdata_q [N_CORES];
  logic [15:0]        conflict_q;
  logic [15:0]        conflict_d;
  logic               found;
  int                 j;
  logic [PTR_W-1:0]   jj;

  always_comb begin
    for (int i = 0; i < N_CORES; i++) begin
      core_bank[i] = addr_in[i*ADDR_W +: BANK_W];
      core_word[i] = addr_in[i*ADDR_W+BANK_W +: WORD_W];
      core_wdat[i] = wdata_in[i*DATA_W +: DATA_W];
      rdata_out[i*DATA_W +: DATA_W] = rdata_q[i];
    end
  end

  // A core whose done is high this cycle was already served and must not be re-granted.
  assign elig = (rd_req | wr_req) & ~done_q;

  always_comb begin
    grant   = '0;
    bank_we = '0;
    found   = 1'b0;
    j       = 0;
    jj      = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      ptr_d[b]     = ptr_q[b];
      bank_widx[b] = '0;
      bank_wdat[b] = '0;
      found        = 1'b0;
      for (int k = 0; k < N_CORES; k++) begin
        j = int'(ptr_q[b]) + k;
        if (j >= N_CORES) j = j - N_CORES;
        jj = PTR_W'(j);
        if (!found && elig[jj] && core_bank[jj] == BANK_W'(b)) begin
          found        = 1'b1;
          grant[jj]    = 1'b1;
          ptr_d[b]     = (j == N_CORES - 1) ? '0 : PTR_W'(j + 1);
          bank_we[b]   = wr_req[jj];
          bank_widx[b] = core_word[jj];
          bank_wdat[b] = core_wdat[jj];
        end
      end
    end
  end

  assign conflict_d = (|(elig & ~grant) && conflict_q != 16'hFFFF) ? conflict_q + 16'd1 : conflict_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q     <= '0;
      conflict_q <= '0;
      for (int b = 0; b < N_BANKS; b++) ptr_q[b] <= '0;
      for (int i = 0; i < N_CORES; i++) rdata_q[i] <= '0;
    end else begin
      done_q     <= grant;
      conflict_q <= conflict_d;
      for (int b = 0; b < N_BANKS; b++) ptr_q[b] <= ptr_d[b];
      for (int i = 0; i < N_CORES; i++) begin
        if (grant[i] && !wr_req[i]) rdata_q[i] <= mem[core_bank[i]][core_word[i]];
      end
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    for (int b = 0; b < N_BANKS; b++) begin
      if (bank_we[b]) mem[b][bank_widx[b]] <= bank_wdat[b];
    end
  end

  assign done         = done_q;
  assign conflict_cnt = conflict_q;

endmodule
